// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, FSM encoding, status bits.
package dmem_pkg;

   localparam logic [1:0] MMIO_TX   = 2'd0;
   localparam logic [1:0] MMIO_RX   = 2'd1;
   localparam logic [1:0] MMIO_STAT = 2'd2;
   localparam logic [1:0] MMIO_CNT  = 2'd3;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE    = 1'b0;
   localparam state_t ST_RD_WAIT = 1'b1;

   localparam int STAT_TX_FULL  = 0;
   localparam int STAT_RX_NE    = 1;
   localparam int STAT_TX_EMPTY = 2;

   localparam logic [1:0] CNT_LOADS  = 2'd0;
   localparam logic [1:0] CNT_STORES = 2'd1;
   localparam logic [1:0] CNT_STALLS = 2'd2;

endpackage

// File: rtl/data_memory_if.sv
// DataMemory bus between the EX/MEM stage (master) and its memory slave.
interface DataMemory;
   logic        en;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        stall;
   logic [31:0] rd;

   modport slave  (input en, we, addr, wd, output stall, rd);
   modport master (output en, we, addr, wd, input stall, rd);
endinterface

// File: rtl/byte_fifo.sv
// Circular byte FIFO; extra pointer MSB distinguishes full from empty.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output logic [7:0] head
);
   localparam int PW = $clog2(DEPTH) + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]    mem [0:DEPTH-1];
   logic          do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
   assign head  = mem[rd_ptr_q[PW-2:0]];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + (do_push ? PW'(1) : PW'(0));
      rd_ptr_d = rd_ptr_q + (do_pop ? PW'(1) : PW'(0));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_q[PW-2:0]] <= push_data;
   end
endmodule

// File: rtl/dmem_responder.sv
// DataMemory slave: BRAM with stall-hidden read latency plus a UART MMIO window.
// Define DMEM_COUNTERS_EN to add load/store/stall counters at MMIO+3.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH      = 65536,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
   input  logic       clock,
   input  logic       reset,
   DataMemory.slave   m_data,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready
);
   localparam int AW = $clog2(DEPTH);

   state_t      state_q, state_d;
   logic        stall_c;
   logic [31:0] rd_c;

   logic [31:0] ram_mem [0:DEPTH-1];
   logic [31:0] ram_rd_q;
   logic        ram_we, ram_re;
   logic [AW-1:0] ram_idx;

   logic        in_ram, in_mmio;
   logic [31:0] offset;
   logic [31:0] status_word;

   logic        tx_push, tx_pop, tx_full, tx_empty;
   logic        rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]  rx_head;

   assign ram_idx = m_data.addr[AW-1:0];
   assign in_ram  = (m_data.addr < 32'(DEPTH));
   assign offset  = m_data.addr - MMIO_BASE;
   assign in_mmio = (offset < 32'd4);

   assign tx_valid = ~tx_empty & ~reset;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_ready = ~rx_full & ~reset;
   assign rx_push  = rx_valid & rx_ready;

   always_comb begin
      status_word                = '0;
      status_word[STAT_TX_FULL]  = tx_full;
      status_word[STAT_RX_NE]    = ~rx_empty;
      status_word[STAT_TX_EMPTY] = tx_empty;
   end

`ifdef DMEM_COUNTERS_EN
   logic [31:0] cnt_q [0:2];
   logic [31:0] cnt_d [0:2];
   logic [1:0]  cnt_sel_q, cnt_sel_d;
   logic        cnt_clear;
   logic        cnt_inc [0:2];
`endif

   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      rd_c    = '0;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
      tx_push = 1'b0;
      rx_pop  = 1'b0;
`ifdef DMEM_COUNTERS_EN
      cnt_sel_d = cnt_sel_q;
      cnt_clear = 1'b0;
      for (int i = 0; i < 3; i++) cnt_inc[i] = 1'b0;
`endif
      if (reset) begin
         state_d = ST_IDLE;
      end else if (state_q == ST_RD_WAIT) begin
         // Read data was captured last edge; a dropped en just abandons it.
         state_d = ST_IDLE;
         if (m_data.en) begin
            rd_c = ram_rd_q;
`ifdef DMEM_COUNTERS_EN
            cnt_inc[CNT_LOADS] = 1'b1;
`endif
         end
      end else if (m_data.en) begin
         if (in_ram) begin
            if (m_data.we) begin
               ram_we = 1'b1;
`ifdef DMEM_COUNTERS_EN
               cnt_inc[CNT_STORES] = 1'b1;
`endif
            end else begin
               ram_re  = 1'b1;
               stall_c = 1'b1;
               state_d = ST_RD_WAIT;
            end
         end else if (in_mmio) begin
            case (offset[1:0])
               MMIO_TX: begin
                  if (m_data.we) begin
                     if (tx_full) stall_c = 1'b1;
                     else         tx_push = 1'b1;
                  end
               end
               MMIO_RX: begin
                  if (!m_data.we) begin
                     if (rx_empty) begin
                        stall_c = 1'b1;
                     end else begin
                        rd_c   = {24'b0, rx_head};
                        rx_pop = 1'b1;
                     end
                  end
               end
               MMIO_STAT: begin
                  if (!m_data.we) rd_c = status_word;
               end
               default: begin
`ifdef DMEM_COUNTERS_EN
                  if (m_data.we) begin
                     cnt_sel_d = m_data.wd[1:0];
                     cnt_clear = m_data.wd[31];
                  end else if (cnt_sel_q != MMIO_CNT) begin
                     rd_c = cnt_q[cnt_sel_q];
                  end
`endif
               end
            endcase
         end
      end
`ifdef DMEM_COUNTERS_EN
      cnt_inc[CNT_STALLS] = m_data.en & stall_c;
      for (int i = 0; i < 3; i++) begin
         if (cnt_clear)                        cnt_d[i] = '0;
         else if (cnt_inc[i] && ~&cnt_q[i])    cnt_d[i] = cnt_q[i] + 32'd1;
         else                                  cnt_d[i] = cnt_q[i];
      end
`endif
   end

   assign m_data.stall = stall_c;
   assign m_data.rd    = rd_c;

   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

`ifdef DMEM_COUNTERS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_sel_q <= CNT_LOADS;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         cnt_sel_q <= cnt_sel_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      end
   end
`endif

   // Inferred block RAM: write-first is not needed since reads are always a cycle later.
   always_ff @(posedge clock) begin
      if (ram_we) ram_mem[ram_idx] <= m_data.wd;
      if (ram_re) ram_rd_q <= ram_mem[ram_idx];
   end

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (tx_push),
      .push_data (m_data.wd[7:0]),
      .pop       (tx_pop),
      .full      (tx_full),
      .empty     (tx_empty),
      .head      (tx_data)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rx_data),
      .pop       (rx_pop),
      .full      (rx_full),
      .empty     (rx_empty),
      .head      (rx_head)
   );
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Slave end of the DataMemory interface; serves the EX/MEM stage's data port.
- Backs a word-addressed block RAM with synchronous read (1-cycle latency). Converts that latency into the interface's stall-based, zero-wait-looking protocol.
- Decodes a small MMIO window: UART TX FIFO, UART RX FIFO and a status word. Plugs between core and UART module.

Parameters:
- DEPTH, 65536, number of 32-bit RAM words; word address range 0..DEPTH-1.
- FIFO_DEPTH, 16, entries per TX/RX byte FIFO; power of two, at least 2.
- MMIO_BASE, 32'hFFFF_FF00, word address of the MMIO window.
  - +0 TX data (write only).
  - +1 RX data (read only).
  - +2 status (read only).
  - +3 counter select (only with counters enabled).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- m_data  DataMemory.slave  bundle  inputs en, we, addr, wd; outputs stall, rd
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  tx_data valid (FIFO not empty)
- tx_ready  input  1  UART accepts byte this cycle
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  responder accepts byte (RX FIFO not full)

Behaviour:
- Protocol:
  - Master drives en/we/addr/wd combinationally. Slave drives stall combinationally in the same cycle.
  - Master holds the request stable while stall=1.
  - A transaction completes in the cycle with en=1 and stall=0. rd is valid only in that cycle; otherwise rd=0.
- FSM states: IDLE, RD_WAIT.
- RAM read (addr<DEPTH, we=0):
  - IDLE + request: issue BRAM read, stall=1, go to RD_WAIT.
  - RD_WAIT: stall=0, rd=BRAM output, go to IDLE.
  - Back-to-back reads therefore take 2 cycles each.
- RAM write (addr<DEPTH, we=1): stall=0, BRAM written at the clock edge, remains in IDLE.
  - A read to the same address in the next cycle returns the new data.
- TX write (MMIO+0, we=1):
  - If TX FIFO not full: push wd[7:0], stall=0.
  - If full: stall=1 until an entry drains.
  - Simultaneous push and pop when full: still stall; the push occurs the next cycle.
- RX read (MMIO+1, we=0):
  - If RX FIFO not empty: rd={24'b0, head}, pop, stall=0.
  - If empty: stall=1 until a byte arrives. A byte pushed this cycle becomes visible next cycle (no bypass).
- Status read (MMIO+2): rd={29'b0, tx_empty, rx_nonempty, tx_full}, stall=0.
- Out-of-range or illegal access (addr≥DEPTH outside MMIO, write to RX/status, read of TX):
  - Writes ignored; reads return 0; stall=0.
- en=0: stall=0, rd=0, no side effects. en must not drop while stall=1; if it does in RD_WAIT, the FSM returns to IDLE.
- FIFOs:
  - Circular, pointer width clog2(FIFO_DEPTH)+1, wrap via MSB compare.
  - TX pops when tx_valid&tx_ready. RX pushes when rx_valid&rx_ready.
- Reset:
  - FSM→IDLE; both FIFOs empty; tx_valid=0; rx_ready=0 during reset, 1 after.
  - stall=0 and rd=0 while reset=1. RAM contents not cleared.
  - Reset while in RD_WAIT aborts the read.
- Priority within a cycle: reset > FSM state > address decode.

Optional Feature:
- Macro DMEM_COUNTERS_EN.
- With it:
  - Three 32-bit saturating counters: completed loads, completed stores, stall cycles (en&stall).
  - Writing MMIO+3 with wd[1:0] selects a counter; wd[31]=1 clears all counters.
  - Reading MMIO+3 returns the selected counter, stall=0. Counters reset to 0.
- Without it: MMIO+3 is treated as out-of-range.

Decomposition:
- Package dmem_pkg:
  - MMIO offset localparams TX=0, RX=1, STAT=2, CNT=3.
  - FSM state enum (IDLE, RD_WAIT).
  - Status bit index constants.
- One sub-module: byte_fifo (param DEPTH; push/pop/full/empty/head), instantiated twice for TX and RX.
- BRAM inferred inline.

Test Plan:
- Write addr 5 ← 32'hDEADBEEF, then read addr 5 → stall=1 for exactly 1 cycle, then rd=32'hDEADBEEF with stall=0.
- Two consecutive reads of addr 5 and 6 (6 preloaded 32'h1) → stall pattern 1,0,1,0; rd 32'hDEADBEEF then 32'h1.
- tx_ready=0, write 17 bytes to MMIO+0:
  - First 16 complete with stall=0; 17th stalls.
  - Raising tx_ready for 1 cycle completes the 17th next cycle.
  - tx_data order is 0x00..0x10.
- Read MMIO+1 with RX empty → stall held.
  - Drive rx_data=8'hA5, rx_valid=1 for 1 cycle.
  - Stall drops the following cycle; rd=32'h000000A5.
  - Status then reads 3'b100.
- Assert reset during RD_WAIT → stall=0, rd=0. After reset: status=3'b100, tx_valid=0, and a fresh read of addr 5 behaves normally with a 1-cycle stall.
- (DMEM_COUNTERS_EN) 3 loads and 2 stores to RAM, select counter 0 then 1:
  - Reads return 3 and 2; the stall counter reads 3.
  - Write wd=32'h8000_0000 → all read 0.
